// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and one-bubble load-use stall control.
// Optional FWD_STATS_EN adds saturating stall/forward cycle counters.
module fwd_hazard_unit #(
  parameter int RA_W   = 4,
  parameter int HI_REG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src1,
  input  logic [RA_W-1:0] id_src2,
  input  logic [1:0]      id_alusrc,
  input  logic [RA_W-1:0] id_dst,
  input  logic            id_wr_en,
  input  logic            id_wide,
  input  logic            id_load,
  input  logic            flush,
  output logic            hazard1,
  output logic [2:0]      fwd1,
  output logic            hazard2,
  output logic [2:0]      fwd2,
  output logic            stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     fwd_cnt
`endif
);

  localparam logic [RA_W-1:0] HI = RA_W'(HI_REG);

  typedef enum logic {S_RUN, S_LU} state_t;

  state_t r_state;
  state_t w_next;

  logic            r_ex_valid;
  logic [RA_W-1:0] r_ex_src1;
  logic [RA_W-1:0] r_ex_src2;
  logic [1:0]      r_ex_alusrc;
  logic [RA_W-1:0] r_ex_dst;
  logic            r_ex_wr;
  logic            r_ex_wide;
  logic            r_ex_load;

  logic            r_mem_valid;
  logic [RA_W-1:0] r_mem_dst;
  logic            r_mem_wr;
  logic            r_mem_wide;
  logic            r_mem_load;

  logic            r_wb_valid;
  logic [RA_W-1:0] r_wb_dst;
  logic            r_wb_wr;
  logic            r_wb_wide;

  logic [1:0] w_m1, w_m2, w_w1, w_w2;
  logic [2:0] w_sel1, w_sel2;
  logic       w_hit;
  logic       w_ld;
  logic       w_stall;

  // 01 = low half of dst, 10 = high half landing in HI_REG
  function automatic logic [1:0] f_match(
    input logic [RA_W-1:0] s,
    input logic            v,
    input logic            wr,
    input logic            wide,
    input logic [RA_W-1:0] dst
  );
    f_match = 2'b00;
    if (v && wr) begin
      if (s == dst)
        f_match = 2'b01;
      else if (wide && s == HI)
        f_match = 2'b10;
    end
  endfunction

  function automatic logic [2:0] f_sel(
    input logic [1:0] m,
    input logic [1:0] w
  );
    if (m[0])      f_sel = 3'b001;
    else if (m[1]) f_sel = 3'b010;
    else if (w[0]) f_sel = 3'b011;
    else if (w[1]) f_sel = 3'b100;
    else           f_sel = 3'b000;
  endfunction

  always_comb begin
    w_m1 = f_match(r_ex_src1, r_mem_valid && !r_mem_load,
                   r_mem_wr, r_mem_wide, r_mem_dst);
    w_m2 = f_match(r_ex_src2, r_mem_valid && !r_mem_load,
                   r_mem_wr, r_mem_wide, r_mem_dst);
    w_w1 = f_match(r_ex_src1, r_wb_valid,
                   r_wb_wr, r_wb_wide, r_wb_dst);
    w_w2 = f_match(r_ex_src2, r_wb_valid,
                   r_wb_wr, r_wb_wide, r_wb_dst);
    w_sel1 = f_sel(w_m1, w_w1);
    w_sel2 = f_sel(w_m2, w_w2);
  end

  always_comb begin
    hazard1 = r_ex_valid && (w_sel1 != 3'b000);
    fwd1    = hazard1 ? w_sel1 : 3'b000;
    hazard2 = r_ex_valid && (r_ex_alusrc == 2'b00)
              && (w_sel2 != 3'b000);
    fwd2    = hazard2 ? w_sel2 : 3'b000;
  end

  always_comb begin
    w_hit = (id_src1 == r_ex_dst)
         || (id_alusrc == 2'b00 && id_src2 == r_ex_dst)
         || (r_ex_wide && (id_src1 == HI
             || (id_alusrc == 2'b00 && id_src2 == HI)));
    w_ld  = r_ex_valid && r_ex_load && r_ex_wr
         && id_valid && !flush && w_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_RUN;
    unique case (r_state)
      S_RUN:   w_next = w_ld ? S_LU : S_RUN;
      S_LU:    w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      S_RUN:   w_stall = w_ld;
      S_LU:    w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  assign stall = w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_src1   <= '0;
      r_ex_src2   <= '0;
      r_ex_alusrc <= 2'b00;
      r_ex_dst    <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_wide   <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_dst   <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_wide  <= 1'b0;
      r_mem_load  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_dst    <= '0;
      r_wb_wr     <= 1'b0;
      r_wb_wide   <= 1'b0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_dst    <= r_mem_dst;
      r_wb_wr     <= r_mem_wr;
      r_wb_wide   <= r_mem_wide;
      r_mem_valid <= r_ex_valid;
      r_mem_dst   <= r_ex_dst;
      r_mem_wr    <= r_ex_wr;
      r_mem_wide  <= r_ex_wide;
      r_mem_load  <= r_ex_load;
      r_ex_valid  <= id_valid && !w_stall && !flush;
      r_ex_src1   <= id_src1;
      r_ex_src2   <= id_src2;
      r_ex_alusrc <= id_alusrc;
      r_ex_dst    <= id_dst;
      r_ex_wr     <= id_wr_en;
      r_ex_wide   <= id_wide;
      r_ex_load   <= id_load;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if ((hazard1 || hazard2) && r_fwd_cnt != 16'hFFFF)
        r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: pipeline-history model
// compared every cycle plus hand-computed literal expectations.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_src1, id_src2, id_dst;
  logic [1:0] id_alusrc;
  logic       id_wr_en, id_wide, id_load, flush;
  logic       hazard1, hazard2, stall;
  logic [2:0] fwd1, fwd2;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RA_W(4), .HI_REG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_alusrc(id_alusrc), .id_dst(id_dst), .id_wr_en(id_wr_en),
    .id_wide(id_wide), .id_load(id_load), .flush(flush),
    .hazard1(hazard1), .fwd1(fwd1),
    .hazard2(hazard2), .fwd2(fwd2), .stall(stall)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  typedef struct {
    bit       v;
    bit [3:0] s1, s2, d;
    bit [1:0] as;
    bit       wr, wide, ld;
  } ins_t;

  // hist[0] = in EX, hist[1] = one older, hist[2] = two older
  ins_t hist[3];

  function automatic bit [2:0] exp_sel(bit [3:0] s);
    for (int r = 1; r <= 2; r++) begin
      bit [2:0] base;
      base = (r == 1) ? 3'd1 : 3'd3;
      if (hist[r].v && hist[r].wr && !(r == 1 && hist[r].ld)) begin
        if (s == hist[r].d) return base;
        if (hist[r].wide && s == 4'd0) return base + 3'd1;
      end
    end
    return 3'd0;
  endfunction

  function automatic bit exp_stall();
    bit rd2, hit;
    if (!(hist[0].v && hist[0].ld && hist[0].wr)) return 1'b0;
    if (!id_valid || flush) return 1'b0;
    rd2 = (id_alusrc == 2'b00);
    hit = (id_src1 == hist[0].d) || (rd2 && id_src2 == hist[0].d);
    if (hist[0].wide)
      hit = hit || id_src1 == 4'd0 || (rd2 && id_src2 == 4'd0);
    return hit;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    ins_t nw;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] <= '{default: 0};
    end else begin
      nw.v    = id_valid && !exp_stall() && !flush;
      nw.s1   = id_src1;
      nw.s2   = id_src2;
      nw.d    = id_dst;
      nw.as   = id_alusrc;
      nw.wr   = id_wr_en;
      nw.wide = id_wide;
      nw.ld   = id_load;
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= nw;
    end
  end

  task automatic check(string n, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      bit [2:0] s1, s2;
      bit h1, h2;
      s1 = exp_sel(hist[0].s1);
      s2 = exp_sel(hist[0].s2);
      h1 = hist[0].v && s1 != 0;
      h2 = hist[0].v && hist[0].as == 2'b00 && s2 != 0;
      check("model_hazard1", {2'b0, hazard1}, {2'b0, h1});
      check("model_fwd1", fwd1, h1 ? s1 : 3'd0);
      check("model_hazard2", {2'b0, hazard2}, {2'b0, h2});
      check("model_fwd2", fwd2, h2 ? s2 : 3'd0);
      check("model_stall", {2'b0, stall}, {2'b0, exp_stall()});
    end
  end

  task automatic drive(bit v, bit [3:0] s1, bit [3:0] s2,
                       bit [1:0] as, bit [3:0] d, bit wr,
                       bit wide, bit ld, bit fl);
    id_valid  = v;
    id_src1   = s1;
    id_src2   = s2;
    id_alusrc = as;
    id_dst    = d;
    id_wr_en  = wr;
    id_wide   = wide;
    id_load   = ld;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 4'd15, 4'd15, 2'b01, 4'd15, 0, 0, 0, 0);
    tick();
  endtask

  task automatic chk_zero(string n);
    check({n, "_h1"}, {2'b0, hazard1}, 3'd0);
    check({n, "_f1"}, fwd1, 3'd0);
    check({n, "_h2"}, {2'b0, hazard2}, 3'd0);
    check({n, "_f2"}, fwd2, 3'd0);
    check({n, "_st"}, {2'b0, stall}, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 4'd15, 4'd15, 2'b01, 4'd15, 0, 0, 0, 0);
    #12;
    chk_zero("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();
    nop();

    // ADD R3 then SUB reading R3 on operand B
    drive(1, 4'd1, 4'd2, 2'b00, 4'd3, 1, 0, 0, 0); tick();
    drive(1, 4'd4, 4'd3, 2'b00, 4'd6, 1, 0, 0, 0); tick();
    check("exmem_h2", {2'b0, hazard2}, 3'd1);
    check("exmem_f2", fwd2, 3'b001);
    check("exmem_h1", {2'b0, hazard1}, 3'd0);
    nop(); nop(); nop();

    // ADD R3, NOP, use R3 on operand A
    drive(1, 4'd1, 4'd2, 2'b00, 4'd3, 1, 0, 0, 0); tick();
    nop();
    drive(1, 4'd3, 4'd8, 2'b00, 4'd7, 1, 0, 0, 0); tick();
    check("memwb_h1", {2'b0, hazard1}, 3'd1);
    check("memwb_f1", fwd1, 3'b011);
    nop(); nop(); nop();

    // wide MUL R5, high half lands in R0
    drive(1, 4'd1, 4'd2, 2'b00, 4'd5, 1, 1, 0, 0); tick();
    drive(1, 4'd0, 4'd5, 2'b00, 4'd9, 1, 0, 0, 0); tick();
    check("wide_f1_mem", fwd1, 3'b010);
    check("wide_f2_mem", fwd2, 3'b001);
    nop(); nop(); nop();
    drive(1, 4'd1, 4'd2, 2'b00, 4'd5, 1, 1, 0, 0); tick();
    drive(1, 4'd7, 4'd8, 2'b00, 4'd9, 1, 0, 0, 0); tick();
    drive(1, 4'd0, 4'd5, 2'b00, 4'd10, 1, 0, 0, 0); tick();
    check("wide_f1_wb", fwd1, 3'b100);
    check("wide_f2_wb", fwd2, 3'b011);
    nop(); nop(); nop();

    // load-use: one bubble, then forward from the oldest record
    drive(1, 4'd1, 4'd2, 2'b01, 4'd4, 1, 0, 1, 0); tick();
    drive(1, 4'd4, 4'd1, 2'b00, 4'd6, 1, 0, 0, 0); #1;
    check("lu_stall", {2'b0, stall}, 3'd1);
    tick();
    check("lu_bubble_h1", {2'b0, hazard1}, 3'd0);
    check("lu_no_2nd_stall", {2'b0, stall}, 3'd0);
    tick();
    check("lu_fwd_h1", {2'b0, hazard1}, 3'd1);
    check("lu_fwd_f1", fwd1, 3'b011);
    nop(); nop(); nop();

    // load-use squashed by flush
    drive(1, 4'd1, 4'd2, 2'b01, 4'd4, 1, 0, 1, 0); tick();
    drive(1, 4'd4, 4'd1, 2'b00, 4'd6, 1, 0, 0, 1); #1;
    check("flush_stall", {2'b0, stall}, 3'd0);
    tick();
    drive(0, 4'd15, 4'd15, 2'b01, 4'd15, 0, 0, 0, 0); #1;
    check("flush_bubble_h1", {2'b0, hazard1}, 3'd0);
    check("flush_bubble_h2", {2'b0, hazard2}, 3'd0);
    tick();
    nop(); nop();

    // immediate operand B is never overridden
    drive(1, 4'd1, 4'd2, 2'b00, 4'd3, 1, 0, 0, 0); tick();
    drive(1, 4'd9, 4'd3, 2'b01, 4'd6, 1, 0, 0, 0); tick();
    check("imm_h2", {2'b0, hazard2}, 3'd0);
    check("imm_f2", fwd2, 3'd0);
    nop(); nop(); nop();

    // reset pulse while in the post-stall cycle
    drive(1, 4'd1, 4'd2, 2'b01, 4'd4, 1, 0, 1, 0); tick();
    drive(1, 4'd4, 4'd1, 2'b00, 4'd6, 1, 0, 0, 0); #1;
    check("rst_pre_stall", {2'b0, stall}, 3'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    #1;
    rst_n = 1'b1;
    nop(); nop();
    drive(1, 4'd1, 4'd2, 2'b01, 4'd4, 1, 0, 1, 0); tick();
    drive(1, 4'd4, 4'd1, 2'b00, 4'd6, 1, 0, 0, 0); #1;
    check("rst_run_stall", {2'b0, stall}, 3'd1);
    tick(); tick();
    nop(); nop(); nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=done");
    $fatal(1);
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard controller for the EX stage. It tracks the destination records of the instructions in EX, EX/MEM (Btb) and MEM/WB (oneAway).
- It drives the hazard/select pairs for both ALU operand muxes. The operand-B pair feeds the operand-B mux directly: hazard2 drives the mux hazard input, fwd2 drives ForwardToMux3.
- It stalls IF/ID for one cycle on load-use dependencies.
- It is upstream of the operand muxes. Its inputs come from the ID decoder.

Parameters:
- RA_W, 4, register address width.
- HI_REG, 0, register that receives bits [31:16] of a wide (32-bit) result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  RA_W  operand-1 register number.
- id_src2  in  RA_W  operand-2 register number.
- id_alusrc  in  2  ALU B source: 00=reg, 01=imm, 10=R15.
- id_dst  in  RA_W  destination register.
- id_wr_en  in  1  instruction writes a register.
- id_wide  in  1  32-bit result: low half to dst, high half to HI_REG.
- id_load  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (taken branch).
- hazard1  out  1  forward operand 1.
- fwd1  out  3  operand-1 select: 001 Btb[15:0], 010 Btb[31:16], 011 oneAway[15:0], 100 oneAway[31:16].
- hazard2  out  1  forward operand 2 (to the ALU B mux).
- fwd2  out  3  operand-2 select, same encoding as fwd1.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.

Behaviour:
- Three internal records: EX, MEM, WB. Fields per record: valid, dst, wr_en, wide, load. The EX record also holds src1, src2 and alusrc.
- Every rising clk: WB<=MEM, MEM<=EX.
- The EX record loads the ID fields, with valid=id_valid, except:
  - if stall or flush is asserted, EX.valid<=0 (bubble); the other EX fields are don't-care.
- Reset (rst_n low, asynchronous): all valid bits are 0 and state is RUN.
- Reset values of outputs: hazard1=0, fwd1=000, hazard2=0, fwd2=000, stall=0.
- Forward match of source s against record R: R.valid && R.wr_en, and then:
  - if s==R.dst, select the low half;
  - else if R.wide && s==HI_REG, select the high half;
  - if dst==HI_REG on a wide result, the low half wins.
- Priority: MEM (001/010) over WB (011/100). A MEM record with load=1 never matches, because its data is not ready.
- Operand 1: hazard1=1 iff a match exists. fwd1 carries the code; fwd1=000 when hazard1=0.
- Operand 2: same rule, and additionally gated by EX.alusrc==00. Imm and R15 operands are never overridden.
- Outputs hazard/fwd are combinational from the registered records. There is zero-cycle latency to the mux.
- Load-use detect (ld): EX.valid && EX.load && EX.wr_en && id_valid && !flush, and ID reads EX.dst via:
  - id_src1, or
  - id_src2 with id_alusrc==00, or
  - HI_REG via either source when EX.wide.
- FSM states:
  - RUN: stall=ld. If ld, go to LU.
  - LU: stall=0 (EX now holds a bubble, so ld cannot recur). Go to RUN unconditionally.
  - After one bubble, the load is in WB when the consumer reaches EX, so the consumer forwards via 011/100.
- flush has priority over stall: with flush=1, stall=0 and EX gets a bubble.
- Reset mid-stall returns to RUN with stall=0.
- Back-to-back loads each cause at most one bubble.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, two output ports are added:
  - stall_cnt (16): counts cycles with stall=1.
  - fwd_cnt (16): counts cycles with hazard1|hazard2.
- Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- ADD R3 then SUB using src2=R3, alusrc=00 -> in SUB's EX cycle: hazard2=1, fwd2=001.
- ADD R3, NOP, then use of R3 as src1 -> hazard1=1, fwd1=011.
- Wide MUL dst=R5 (HI_REG=0), then instruction reading src1=R0 and src2=R5 -> fwd1=010, fwd2=001. Same pair one instruction later -> fwd1=100, fwd2=011.
- LOAD R4, then ADD reading R4 -> stall=1 for exactly one cycle, EX bubble. Next cycle: consumer in EX with hazard=1, fwd=011. No second stall.
- Same load-use with flush=1 in the detect cycle -> stall=0, EX bubble, no forwarding afterwards.
- Dependent with alusrc=01; also rst_n pulsed low during the LU state -> hazard2=0 for the dependent. After the reset pulse, all outputs are 0 immediately and the state is RUN.
